cpu_pipeline_control: RTL and testbench
=======================================

CPU_PIPELINE_CONTROL -- requirements
Module: cpu_pipeline_control

Interface
REQ-001 SHALL have these parameters: REG_W, default 3, register index width; CNT_W, default 16, statistics counter width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_de_jump_i  in  1  decode-stage instruction is a taken immediate jump (j/jz/jn/call).
REQ-005 SHALL have port i_ex_jump_r  in  1  execute-stage instruction is a taken register jump (jr/jzr/jnr/callr).
REQ-006 SHALL have ports i_de_rd_rx, i_de_rd_ry  in  1 each  decode instruction reads rx / ry.
REQ-007 SHALL have ports i_de_rx, i_de_ry  in  REG_W each  decode source register indices.
REQ-008 SHALL have ports i_ex_wr, i_rfw_wr  in  1 each  execute / writeback instruction writes a register.
REQ-009 SHALL have ports i_ex_rw, i_rfw_rw  in  REG_W each  execute / writeback destination indices.
REQ-010 SHALL have port i_rfw_halt  in  1  writeback-stage instruction is halt.
REQ-011 SHALL have ports o_pc_rd  out  1  instruction-port read strobe; o_pc_addr_sel  out  2  0=PC+2, 1=immediate target, 2=register target.
REQ-012 SHALL have ports o_pc_en  out  1  PC register update enable; o_de_hold  out  1  decode instruction register holds.
REQ-013 SHALL have ports o_de_valid, o_ex_valid, o_rfw_valid  out  1 each  stage-valid bits.
REQ-014 SHALL have ports o_halted  out  1  halt state; o_stall_cycles, o_flush_count  out  CNT_W each  statistics.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; reset -> BOOT; BOOT -> RUN after exactly one cycle; RUN -> HALT when i_rfw_halt & rfw_valid; HALT left only by reset.
REQ-016 BOOT SHALL drive o_pc_rd=1, sel=0, o_pc_en=1, and set de_valid next cycle.
REQ-017 Definitions: jr = ex_valid & i_ex_jump_r; hazard = de_valid & ((rd_rx & match(rx)) | (rd_ry & match(ry))), where match(r) = (ex_valid & i_ex_wr & i_ex_rw==r) | (rfw_valid & i_rfw_wr & i_rfw_rw==r); ji = de_valid & i_de_jump_i & ~hazard.
REQ-018 RUN priority SHALL be jr > hazard > ji > normal.
REQ-019 jr: pc_rd=1, sel=2, pc_en=1; next de_valid=1, ex_valid=0 (decode instruction squashed), rfw_valid=ex_valid; flush_count +1.
REQ-020 hazard (no jr): pc_rd=0, sel=0, pc_en=0, de_hold=1; de_valid unchanged, next ex_valid=0 (bubble), rfw_valid=ex_valid; stall_cycles +1.
REQ-021 ji: pc_rd=1, sel=1, pc_en=1; next de_valid=1, ex_valid=1, rfw_valid=ex_valid.
REQ-022 normal: pc_rd=1, sel=0, pc_en=1; pipeline advances (ex<-de, rfw<-ex, de<-1).
REQ-023 HALT SHALL drive pc_rd=0, pc_en=0, de_hold=1, all valid bits 0, o_halted=1; counters frozen.
REQ-024 Counters SHALL saturate at all-ones, never wrap.
REQ-025 A hazard against an invalid stage SHALL NOT stall; an rx/ry match with rd_* low SHALL NOT stall.
REQ-026 Outputs o_pc_* and o_de_hold SHALL be combinational from state and inputs; valid bits and counters registered.

Reset
REQ-027 On reset SHALL set: state BOOT, all valid bits 0, counters 0, o_halted 0; the combinational outputs take their BOOT values (pc_rd=1, sel=0, pc_en=1, de_hold=0) in the cycle reset is deasserted.
REQ-028 Reset asserted mid-stall, mid-jump or in HALT SHALL override all other activity in that cycle.

Structure
REQ-029 Package cpu_pkg SHALL hold the pc_sel enum (PC_SEL_INC=0, PC_SEL_IMM=1, PC_SEL_REG=2), the FSM state enum, REG_W and CNT_W defaults.
REQ-030 Sub-module cpu_hazard_detect SHALL implement the combinational match/hazard logic of REQ-017.

Verification
REQ-031 Reset release, no hazards -> BOOT 1 cycle, then o_de_valid=1, o_ex_valid=1, o_rfw_valid=1 on the 2nd, 3rd and 4th cycles after release; sel=0 throughout.
REQ-032 de reads rx=3 while ex writes r3 -> 2 stall cycles (ex then rfw); o_pc_en=0 both; o_stall_cycles=2; bubbles on ex_valid.
REQ-033 jr in ex with a jump_i in de in the same cycle -> sel=2, next ex_valid=0, flush_count=1, no sel=1 issued.
REQ-034 jump_i in de with a simultaneous hazard -> sel=0, pc_en=0 until hazard clears, then sel=1 for exactly one cycle.
REQ-035 halt reaches rfw -> o_halted=1 next cycle, all valid bits 0, counters stable; reset -> state BOOT, counters 0.
REQ-036 Force 65540 hazard cycles -> o_stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline controller: PC source select,
// controller FSM states and default widths.
package cpu_pkg;

    localparam int REG_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        PC_SEL_INC = 2'd0,
        PC_SEL_IMM = 2'd1,
        PC_SEL_REG = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_hazard_detect.sv
// Read-after-write hazard between the decode-stage sources and the
// destinations of the execute and writeback stages.
module cpu_hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic             de_valid,
    input  logic             ex_valid,
    input  logic             rfw_valid,
    input  logic             rd_rx,
    input  logic             rd_ry,
    input  logic [REG_W-1:0] rx,
    input  logic [REG_W-1:0] ry,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] ex_rw,
    input  logic             rfw_wr,
    input  logic [REG_W-1:0] rfw_rw,
    output logic             hazard
);

    logic ex_live;
    logic rfw_live;
    logic match_rx;
    logic match_ry;

    // Only a valid stage that actually writes can block decode.
    assign ex_live  = ex_valid & ex_wr;
    assign rfw_live = rfw_valid & rfw_wr;

    assign match_rx = (ex_live & (ex_rw == rx)) | (rfw_live & (rfw_rw == rx));
    assign match_ry = (ex_live & (ex_rw == ry)) | (rfw_live & (rfw_rw == ry));

    assign hazard = de_valid & ((rd_rx & match_rx) | (rd_ry & match_ry));

endmodule

// File: rtl/cpu_pipeline_control.sv
// Three-stage pipeline controller: PC source/enable, decode hold,
// stage-valid tracking, halt handling and stall/flush statistics.
module cpu_pipeline_control
    import cpu_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_de_jump_i,
    input  logic             i_ex_jump_r,
    input  logic             i_de_rd_rx,
    input  logic             i_de_rd_ry,
    input  logic [REG_W-1:0] i_de_rx,
    input  logic [REG_W-1:0] i_de_ry,
    input  logic             i_ex_wr,
    input  logic             i_rfw_wr,
    input  logic [REG_W-1:0] i_ex_rw,
    input  logic [REG_W-1:0] i_rfw_rw,
    input  logic             i_rfw_halt,
    output logic             o_pc_rd,
    output logic [1:0]       o_pc_addr_sel,
    output logic             o_pc_en,
    output logic             o_de_hold,
    output logic             o_de_valid,
    output logic             o_ex_valid,
    output logic             o_rfw_valid,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    state_e  state;
    state_e  state_next;
    pc_sel_e sel;

    logic de_valid;
    logic ex_valid;
    logic rfw_valid;
    logic de_next;
    logic ex_next;
    logic rfw_next;
    logic hazard;
    logic jr;
    logic ji;
    logic stall_inc;
    logic flush_inc;

    cpu_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .de_valid (de_valid),
        .ex_valid (ex_valid),
        .rfw_valid(rfw_valid),
        .rd_rx    (i_de_rd_rx),
        .rd_ry    (i_de_rd_ry),
        .rx       (i_de_rx),
        .ry       (i_de_ry),
        .ex_wr    (i_ex_wr),
        .ex_rw    (i_ex_rw),
        .rfw_wr   (i_rfw_wr),
        .rfw_rw   (i_rfw_rw),
        .hazard   (hazard)
    );

    assign jr = ex_valid & i_ex_jump_r;
    assign ji = de_valid & i_de_jump_i & ~hazard;

    always_comb begin
        state_next = state;
        sel        = PC_SEL_INC;
        o_pc_rd    = 1'b0;
        o_pc_en    = 1'b0;
        o_de_hold  = 1'b0;
        de_next    = de_valid;
        ex_next    = ex_valid;
        rfw_next   = rfw_valid;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        unique case (state)
            ST_BOOT: begin
                o_pc_rd    = 1'b1;
                o_pc_en    = 1'b1;
                de_next    = 1'b1;
                ex_next    = 1'b0;
                rfw_next   = 1'b0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                rfw_next = ex_valid;
                if (jr) begin
                    // The decode instruction is on the wrong path.
                    o_pc_rd   = 1'b1;
                    o_pc_en   = 1'b1;
                    sel       = PC_SEL_REG;
                    de_next   = 1'b1;
                    ex_next   = 1'b0;
                    flush_inc = 1'b1;
                end else if (hazard) begin
                    o_de_hold = 1'b1;
                    ex_next   = 1'b0;
                    stall_inc = 1'b1;
                end else if (ji) begin
                    o_pc_rd = 1'b1;
                    o_pc_en = 1'b1;
                    sel     = PC_SEL_IMM;
                    de_next = 1'b1;
                    ex_next = 1'b1;
                end else begin
                    o_pc_rd = 1'b1;
                    o_pc_en = 1'b1;
                    de_next = 1'b1;
                    ex_next = de_valid;
                end
                if (i_rfw_halt && rfw_valid) begin
                    state_next = ST_HALT;
                    de_next    = 1'b0;
                    ex_next    = 1'b0;
                    rfw_next   = 1'b0;
                end
            end
            ST_HALT: begin
                o_de_hold = 1'b1;
                de_next   = 1'b0;
                ex_next   = 1'b0;
                rfw_next  = 1'b0;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_BOOT;
            de_valid       <= 1'b0;
            ex_valid       <= 1'b0;
            rfw_valid      <= 1'b0;
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
        end else begin
            state     <= state_next;
            de_valid  <= de_next;
            ex_valid  <= ex_next;
            rfw_valid <= rfw_next;
            if (stall_inc && (o_stall_cycles != '1))
                o_stall_cycles <= o_stall_cycles + CNT_W'(1);
            if (flush_inc && (o_flush_count != '1))
                o_flush_count <= o_flush_count + CNT_W'(1);
        end
    end

    assign o_pc_addr_sel = sel;
    assign o_de_valid    = de_valid;
    assign o_ex_valid    = ex_valid;
    assign o_rfw_valid   = rfw_valid;
    assign o_halted      = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_pipeline_control.sv
// Scoreboard bench for cpu_pipeline_control: per-cycle expected output
// vectors are queued with the stimulus and popped as each cycle is sampled.
module tb_cpu_pipeline_control;

    logic        clk;
    logic        reset;
    logic        i_de_jump_i;
    logic        i_ex_jump_r;
    logic        i_de_rd_rx;
    logic        i_de_rd_ry;
    logic [2:0]  i_de_rx;
    logic [2:0]  i_de_ry;
    logic        i_ex_wr;
    logic        i_rfw_wr;
    logic [2:0]  i_ex_rw;
    logic [2:0]  i_rfw_rw;
    logic        i_rfw_halt;
    logic        o_pc_rd;
    logic [1:0]  o_pc_addr_sel;
    logic        o_pc_en;
    logic        o_de_hold;
    logic        o_de_valid;
    logic        o_ex_valid;
    logic        o_rfw_valid;
    logic        o_halted;
    logic [15:0] o_stall_cycles;
    logic [15:0] o_flush_count;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic       ji;
        logic       jr;
        logic       rdx;
        logic       rdy;
        logic [2:0] rx;
        logic [2:0] ry;
        logic       exwr;
        logic [2:0] exrw;
        logic       rfwwr;
        logic [2:0] rfwrw;
        logic       halt;
    } stim_t;

    stim_t       sq[$];
    logic [8:0]  eq[$];
    logic [15:0] cq[$];

    // vector: {de, ex, rfw, sel[1:0], pc_en, pc_rd, de_hold, halted}
    localparam logic [8:0] V_BOOT = 9'b000_00_1100;
    localparam logic [8:0] V_HALT = 9'b000_00_0011;

    cpu_pipeline_control dut (
        .clk           (clk),
        .reset         (reset),
        .i_de_jump_i   (i_de_jump_i),
        .i_ex_jump_r   (i_ex_jump_r),
        .i_de_rd_rx    (i_de_rd_rx),
        .i_de_rd_ry    (i_de_rd_ry),
        .i_de_rx       (i_de_rx),
        .i_de_ry       (i_de_ry),
        .i_ex_wr       (i_ex_wr),
        .i_rfw_wr      (i_rfw_wr),
        .i_ex_rw       (i_ex_rw),
        .i_rfw_rw      (i_rfw_rw),
        .i_rfw_halt    (i_rfw_halt),
        .o_pc_rd       (o_pc_rd),
        .o_pc_addr_sel (o_pc_addr_sel),
        .o_pc_en       (o_pc_en),
        .o_de_hold     (o_de_hold),
        .o_de_valid    (o_de_valid),
        .o_ex_valid    (o_ex_valid),
        .o_rfw_valid   (o_rfw_valid),
        .o_halted      (o_halted),
        .o_stall_cycles(o_stall_cycles),
        .o_flush_count (o_flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs();
        return {o_de_valid, o_ex_valid, o_rfw_valid, o_pc_addr_sel,
                o_pc_en, o_pc_rd, o_de_hold, o_halted};
    endfunction

    function automatic stim_t haz(input logic [2:0] r);
        stim_t s;
        s = '0;
        s.rdx = 1'b1;
        s.rx = r;
        s.exwr = 1'b1;
        s.exrw = r;
        s.rfwwr = 1'b1;
        s.rfwrw = r;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_de_jump_i = s.ji;
        i_ex_jump_r = s.jr;
        i_de_rd_rx  = s.rdx;
        i_de_rd_ry  = s.rdy;
        i_de_rx     = s.rx;
        i_de_ry     = s.ry;
        i_ex_wr     = s.exwr;
        i_ex_rw     = s.exrw;
        i_rfw_wr    = s.rfwwr;
        i_rfw_rw    = s.rfwrw;
        i_rfw_halt  = s.halt;
    endtask

    // Reset, then idle until all three stages hold valid instructions.
    task automatic reset_fill();
        @(negedge clk);
        reset = 1'b1;
        apply('0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8:0] e;
        @(negedge clk);
        reset = 1'b1;
        apply('0);
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== V_BOOT || o_stall_cycles !== 16'd0 || o_flush_count !== 16'd0)
            $display("FAIL reset_hold got %b/%0d/%0d want %b/0/0",
                     obs(), o_stall_cycles, o_flush_count, V_BOOT);
        else passed++;
        eq.push_back(V_BOOT);
        eq.push_back(9'b100_00_1100);
        eq.push_back(9'b110_00_1100);
        eq.push_back(9'b111_00_1100);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            e = eq.pop_front();
            checks++;
            if (obs() !== e)
                $display("FAIL reset_release_c%0d got %b want %b", i + 1, obs(), e);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_hazard();
        stim_t s;
        logic [8:0] e;
        reset_fill();
        sq.push_back(haz(3'd3));  eq.push_back(9'b111_00_0010);
        sq.push_back(haz(3'd3));  eq.push_back(9'b101_00_0010);
        sq.push_back(haz(3'd3));  eq.push_back(9'b100_00_1100);
        s = haz(3'd3);
        s.rdx = 1'b0;
        sq.push_back(s);          eq.push_back(9'b110_00_1100);
        s.rdy = 1'b1;
        s.ry = 3'd3;
        s.rx = 3'd0;
        sq.push_back(s);          eq.push_back(9'b111_00_0010);
        sq.push_back('0);         eq.push_back(9'b101_00_1100);
        for (int i = 0; sq.size() > 0; i++) begin
            apply(sq.pop_front());
            #1;
            e = eq.pop_front();
            checks++;
            if (obs() !== e)
                $display("FAIL hazard_c%0d got %b want %b", i, obs(), e);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (o_stall_cycles !== 16'd3 || o_flush_count !== 16'd0)
            $display("FAIL hazard_counts got %0d/%0d want 3/0",
                     o_stall_cycles, o_flush_count);
        else passed++;
    endtask

    task automatic test_jump();
        stim_t s;
        logic [8:0] e;
        reset_fill();
        s = '0; s.ji = 1'b1; s.jr = 1'b1;
        sq.push_back(s);  eq.push_back(9'b111_10_1100);
        s = '0; s.jr = 1'b1;
        sq.push_back(s);  eq.push_back(9'b101_00_1100);
        s = '0; s.ji = 1'b1;
        sq.push_back(s);  eq.push_back(9'b110_01_1100);
        sq.push_back('0); eq.push_back(9'b111_00_1100);
        for (int i = 0; sq.size() > 0; i++) begin
            apply(sq.pop_front());
            #1;
            e = eq.pop_front();
            checks++;
            if (obs() !== e)
                $display("FAIL jump_c%0d got %b want %b", i, obs(), e);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (o_flush_count !== 16'd1 || o_stall_cycles !== 16'd0)
            $display("FAIL jump_counts got %0d/%0d want 1/0",
                     o_flush_count, o_stall_cycles);
        else passed++;
    endtask

    task automatic test_jump_hazard();
        stim_t s;
        logic [8:0] e;
        reset_fill();
        s = haz(3'd2);
        s.ji = 1'b1;
        sq.push_back(s);  eq.push_back(9'b111_00_0010);
        sq.push_back(s);  eq.push_back(9'b101_00_0010);
        sq.push_back(s);  eq.push_back(9'b100_01_1100);
        sq.push_back('0); eq.push_back(9'b110_00_1100);
        for (int i = 0; sq.size() > 0; i++) begin
            apply(sq.pop_front());
            #1;
            e = eq.pop_front();
            checks++;
            if (obs() !== e)
                $display("FAIL jump_hazard_c%0d got %b want %b", i, obs(), e);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (o_stall_cycles !== 16'd2)
            $display("FAIL jump_hazard_stalls got %0d want 2", o_stall_cycles);
        else passed++;
    endtask

    task automatic test_reset_override();
        reset_fill();
        apply(haz(3'd5));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== V_BOOT || o_stall_cycles !== 16'd0)
            $display("FAIL reset_mid_stall got %b/%0d want %b/0",
                     obs(), o_stall_cycles, V_BOOT);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_halt();
        stim_t s;
        logic [8:0] e;
        reset_fill();
        s = '0; s.rdx = 1'b1; s.rx = 3'd1; s.exwr = 1'b1; s.exrw = 3'd1;
        sq.push_back(s);  eq.push_back(9'b111_00_0010);
        s = '0; s.halt = 1'b1;
        sq.push_back(s);  eq.push_back(9'b101_00_1100);
        s = haz(3'd4); s.ji = 1'b1; s.jr = 1'b1; s.halt = 1'b1;
        sq.push_back(s);  eq.push_back(V_HALT);
        sq.push_back(s);  eq.push_back(V_HALT);
        sq.push_back('0); eq.push_back(V_HALT);
        for (int i = 0; sq.size() > 0; i++) begin
            apply(sq.pop_front());
            #1;
            e = eq.pop_front();
            checks++;
            if (obs() !== e)
                $display("FAIL halt_c%0d got %b want %b", i, obs(), e);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (o_stall_cycles !== 16'd1 || o_flush_count !== 16'd0)
            $display("FAIL halt_counts got %0d/%0d want 1/0",
                     o_stall_cycles, o_flush_count);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== V_BOOT || o_stall_cycles !== 16'd0)
            $display("FAIL halt_reset got %b/%0d want %b/0",
                     obs(), o_stall_cycles, V_BOOT);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [15:0] c;
        reset_fill();
        // A steady hazard stalls two of every three cycles.
        apply(haz(3'd3));
        cq.push_back(16'd2000);
        cq.push_back(16'hFFFF);
        for (int i = 0; i < 3000; i++) @(negedge clk);
        c = cq.pop_front();
        checks++;
        if (o_stall_cycles !== c)
            $display("FAIL stall_count_mid got %0d want %0d", o_stall_cycles, c);
        else passed++;
        for (int i = 0; i < 95310; i++) @(negedge clk);
        c = cq.pop_front();
        checks++;
        if (o_stall_cycles !== c)
            $display("FAIL stall_saturate got %h want %h", o_stall_cycles, c);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        apply('0);
        test_reset();
        test_hazard();
        test_jump();
        test_jump_hazard();
        test_reset_override();
        test_halt();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
